vending_ctrl: RTL and testbench

Parametrised coin-operated vending controller and the next generation of the team's coffee-machine FSMs. It accepts coins of four configurable denominations through a valid/ready handshake and accumulates credit. It issues a one-cycle vend pulse once credit reaches PRICE, returns change or refunds credit on cancel through a valid/ready handshake, and counts vends. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vending_ctrl.sv | 134 +++++++++++++
 tb/tb_vending_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: accumulates credit from four coin denominations,
// pulses vend at PRICE, and returns change/refunds through a valid/ready handshake.
module vending_ctrl #(
    parameter int PRICE     = 15,
    parameter int COIN_VAL0 = 5,
    parameter int COIN_VAL1 = 10,
    parameter int COIN_VAL2 = 25,
    parameter int COIN_VAL3 = 50,
    parameter int CREDIT_W  = 7,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    output logic                coin_ready,
    input  logic                cancel,
    output logic                vend,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    input  logic                change_ready,
    output logic [CNT_W-1:0]    vend_count
);

    localparam int MAX01    = (COIN_VAL0 > COIN_VAL1) ? COIN_VAL0 : COIN_VAL1;
    localparam int MAX23    = (COIN_VAL2 > COIN_VAL3) ? COIN_VAL2 : COIN_VAL3;
    localparam int MAX_COIN = (MAX01 > MAX23) ? MAX01 : MAX23;

    // Largest reachable sum is PRICE-1 of leftover credit plus the biggest coin.
    if (PRICE <= 0 || (PRICE - 1 + MAX_COIN) >= (2 ** CREDIT_W)) begin : g_param_err
        $error("vending_ctrl: PRICE must be >0 and CREDIT_W must hold PRICE-1+max coin");
    end

    typedef enum logic [1:0] {S_COLLECT, S_VEND, S_REFUND} state_t;

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] coin_val, sum;
    logic [CREDIT_W-1:0] credit_nxt, amount_nxt;
    logic                vend_nxt, cv_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                coin_acc;

    assign coin_ready = (state == S_COLLECT);
    assign coin_acc   = coin_valid && coin_ready;

    always_comb begin
        coin_val = CREDIT_W'(COIN_VAL0);
        case (coin_sel)
            2'd0: coin_val = CREDIT_W'(COIN_VAL0);
            2'd1: coin_val = CREDIT_W'(COIN_VAL1);
            2'd2: coin_val = CREDIT_W'(COIN_VAL2);
            2'd3: coin_val = CREDIT_W'(COIN_VAL3);
            default: coin_val = CREDIT_W'(COIN_VAL0);
        endcase
    end

    assign sum = credit + coin_val;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        vend_nxt   = 1'b0;
        cv_nxt     = change_valid;
        amount_nxt = change_amount;
        count_nxt  = vend_count;
        case (state)
            S_COLLECT: begin
                if (coin_acc) begin
                    if (sum >= CREDIT_W'(PRICE)) begin
                        // A completed purchase wins over a simultaneous cancel.
                        state_nxt  = S_VEND;
                        vend_nxt   = 1'b1;
                        credit_nxt = sum - CREDIT_W'(PRICE);
                        count_nxt  = vend_count + 1'b1;
                    end else begin
                        credit_nxt = sum;
                        if (cancel) begin
                            state_nxt  = S_REFUND;
                            cv_nxt     = 1'b1;
                            amount_nxt = sum;
                        end
                    end
                end else if (cancel && credit != '0) begin
                    state_nxt  = S_REFUND;
                    cv_nxt     = 1'b1;
                    amount_nxt = credit;
                end
            end
            S_VEND: begin
                if (credit != '0) begin
                    state_nxt  = S_REFUND;
                    cv_nxt     = 1'b1;
                    amount_nxt = credit;
                end else begin
                    state_nxt = S_COLLECT;
                end
            end
            S_REFUND: begin
                if (change_ready) begin
                    state_nxt  = S_COLLECT;
                    credit_nxt = '0;
                    cv_nxt     = 1'b0;
                    amount_nxt = '0;
                end
            end
            default: begin
                state_nxt  = S_COLLECT;
                credit_nxt = '0;
                cv_nxt     = 1'b0;
                amount_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_COLLECT;
            credit        <= '0;
            vend          <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            vend_count    <= '0;
        end else begin
            state         <= state_nxt;
            credit        <= credit_nxt;
            vend          <= vend_nxt;
            change_valid  <= cv_nxt;
            change_amount <= amount_nxt;
            vend_count    <= count_nxt;
        end
    end

endmodule

// File: tb/tb_vending_ctrl.sv
// Scenario tasks plus a randomized run against a cycle-level purchase model of the vending controller.
module tb_vending_ctrl;
    localparam int PRICE = 15;

    logic       clk = 1'b0, reset = 1'b1;
    logic       coin_valid = 1'b0, cancel = 1'b0, change_ready = 1'b0;
    logic [1:0] coin_sel = 2'd0;
    logic       coin_ready, vend, change_valid;
    logic [6:0] credit, change_amount;
    logic [7:0] vend_count;
    logic       coin_ready2, vend2, change_valid2;
    logic [6:0] credit2, change_amount2;
    logic [1:0] vend_count2;

    int errors = 0, checks = 0;
    int vals[4] = '{5, 10, 25, 50};

    vending_ctrl u_dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .coin_ready(coin_ready), .cancel(cancel), .vend(vend), .credit(credit),
        .change_valid(change_valid), .change_amount(change_amount),
        .change_ready(change_ready), .vend_count(vend_count));

    vending_ctrl #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .coin_ready(coin_ready2), .cancel(cancel), .vend(vend2), .credit(credit2),
        .change_valid(change_valid2), .change_amount(change_amount2),
        .change_ready(change_ready), .vend_count(vend_count2));

    always #5 clk = ~clk;

    // Reference: a pending dispense, an owed refund, and plain integer bookkeeping.
    bit m_vend, m_owed;
    int m_credit, m_amt, m_cnt;
    always @(posedge clk) begin : model
        int s;
        if (reset) begin
            m_vend = 0; m_owed = 0; m_credit = 0; m_amt = 0; m_cnt = 0;
        end else if (m_vend) begin
            m_vend = 0;
            if (m_credit > 0) begin m_owed = 1; m_amt = m_credit; end
        end else if (m_owed) begin
            if (change_ready) begin m_owed = 0; m_credit = 0; m_amt = 0; end
        end else if (coin_valid) begin
            s = m_credit + vals[coin_sel];
            if (s >= PRICE) begin
                m_vend = 1; m_credit = s - PRICE; m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_credit = s;
                if (cancel) begin m_owed = 1; m_amt = s; end
            end
        end else if (cancel && m_credit > 0) begin
            m_owed = 1; m_amt = m_credit;
        end
    end

    task automatic cyc(input bit v, input logic [1:0] s, input bit c, input bit r);
        coin_valid = v; coin_sel = s; cancel = c; change_ready = r;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        checks++;
        if ({vend, change_valid, coin_ready, credit, change_amount, vend_count} !== {3'b001, 7'd0, 7'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset: vend=%0b cv=%0b rdy=%0b credit=%0d amt=%0d cnt=%0d, want 0 0 1 0 0 0",
                     vend, change_valid, coin_ready, credit, change_amount, vend_count);
        end
    endtask

    task automatic test_exact();
        cyc(1, 0, 0, 0);
        checks++;
        if ({vend, credit} !== {1'b0, 7'd5}) begin
            errors++; $display("FAIL exact_first: vend=%0b credit=%0d, want 0 5", vend, credit);
        end
        cyc(1, 1, 0, 0);
        checks++;
        if ({vend, change_valid, coin_ready, credit, vend_count} !== {3'b100, 7'd0, 8'd1}) begin
            errors++;
            $display("FAIL exact_vend: vend=%0b cv=%0b rdy=%0b credit=%0d cnt=%0d, want 1 0 0 0 1",
                     vend, change_valid, coin_ready, credit, vend_count);
        end
        cyc(0, 0, 0, 0);
        checks++;
        if ({vend, change_valid, coin_ready, credit} !== {3'b001, 7'd0}) begin
            errors++;
            $display("FAIL exact_after: vend=%0b cv=%0b rdy=%0b credit=%0d, want 0 0 1 0",
                     vend, change_valid, coin_ready, credit);
        end
    endtask

    task automatic test_change();
        cyc(1, 3, 0, 0);
        checks++;
        if ({vend, credit, vend_count} !== {1'b1, 7'd35, 8'd2}) begin
            errors++; $display("FAIL change_vend: vend=%0b credit=%0d cnt=%0d, want 1 35 2", vend, credit, vend_count);
        end
        cyc(0, 0, 0, 0);
        checks++;
        if ({vend, change_valid, change_amount} !== {2'b01, 7'd35}) begin
            errors++; $display("FAIL change_present: vend=%0b cv=%0b amt=%0d, want 0 1 35", vend, change_valid, change_amount);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            checks++;
            if ({change_valid, coin_ready, change_amount} !== {2'b10, 7'd35}) begin
                errors++; $display("FAIL change_hold%0d: cv=%0b rdy=%0b amt=%0d, want 1 0 35", i, change_valid, coin_ready, change_amount);
            end
        end
        cyc(0, 0, 0, 1);
        checks++;
        if ({change_valid, coin_ready, credit, change_amount} !== {2'b01, 7'd0, 7'd0}) begin
            errors++; $display("FAIL change_done: cv=%0b rdy=%0b credit=%0d amt=%0d, want 0 1 0 0", change_valid, coin_ready, credit, change_amount);
        end
    endtask

    task automatic test_cancel();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        checks++;
        if ({change_valid, change_amount, vend} !== {1'b1, 7'd5, 1'b0}) begin
            errors++; $display("FAIL cancel_refund: cv=%0b amt=%0d vend=%0b, want 1 5 0", change_valid, change_amount, vend);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        checks++;
        if ({change_valid, vend, coin_ready, credit} !== {3'b001, 7'd0}) begin
            errors++; $display("FAIL cancel_empty: cv=%0b vend=%0b rdy=%0b credit=%0d, want 0 0 1 0", change_valid, vend, coin_ready, credit);
        end
    endtask

    task automatic test_coin_cancel();
        cyc(1, 1, 1, 0);
        checks++;
        if ({change_valid, vend, change_amount, credit} !== {2'b10, 7'd10, 7'd10}) begin
            errors++; $display("FAIL coin_cancel: cv=%0b vend=%0b amt=%0d credit=%0d, want 1 0 10 10", change_valid, vend, change_amount, credit);
        end
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        checks++;
        if ({vend, change_valid, credit, vend_count} !== {2'b10, 7'd5, 8'd3}) begin
            errors++; $display("FAIL vend_beats_cancel: vend=%0b cv=%0b credit=%0d cnt=%0d, want 1 0 5 3", vend, change_valid, credit, vend_count);
        end
        cyc(0, 0, 0, 0);
        checks++;
        if ({change_valid, change_amount} !== {1'b1, 7'd5}) begin
            errors++; $display("FAIL vend_change5: cv=%0b amt=%0d, want 1 5", change_valid, change_amount);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_blocked();
        cyc(1, 2, 0, 0);
        cyc(1, 3, 0, 0);
        checks++;
        if ({vend, change_valid, credit, change_amount} !== {2'b01, 7'd10, 7'd10}) begin
            errors++; $display("FAIL coin_in_vend: vend=%0b cv=%0b credit=%0d amt=%0d, want 0 1 10 10", vend, change_valid, credit, change_amount);
        end
        cyc(1, 3, 1, 0);
        checks++;
        if ({change_valid, credit, change_amount} !== {1'b1, 7'd10, 7'd10}) begin
            errors++; $display("FAIL coin_in_refund: cv=%0b credit=%0d amt=%0d, want 1 10 10", change_valid, credit, change_amount);
        end
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        checks++;
        if ({change_valid, vend, coin_ready, credit, change_amount, vend_count} !== {3'b001, 7'd0, 7'd0, 8'd0}) begin
            errors++; $display("FAIL reset_mid_refund: cv=%0b vend=%0b rdy=%0b credit=%0d amt=%0d cnt=%0d, want 0 0 1 0 0 0",
                               change_valid, vend, coin_ready, credit, change_amount, vend_count);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] want;
        for (int i = 0; i < 5; i++) begin
            want = 2'((i + 1) % 4);
            cyc(1, 2, 0, 0);
            checks++;
            if ({vend2, vend_count2} !== {1'b1, want}) begin
                errors++; $display("FAIL wrap_cnt%0d: vend=%0b cnt=%0d, want 1 %0d", i, vend2, vend_count2, want);
            end
            cyc(0, 0, 0, 0);
            checks++;
            if ({change_valid2, change_amount2} !== {1'b1, 7'd10}) begin
                errors++; $display("FAIL wrap_change%0d: cv=%0b amt=%0d, want 1 10", i, change_valid2, change_amount2);
            end
            cyc(0, 0, 0, 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, want;
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
            got  = {vend, change_valid, coin_ready, credit, change_amount, vend_count, vend_count2};
            want = {m_vend, m_owed, !(m_vend || m_owed), 7'(m_credit), 7'(m_amt), 8'(m_cnt), 2'(m_cnt)};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL random%0d: got %h want %h", i, got, want);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exact();
        test_change();
        test_cancel();
        test_coin_cancel();
        test_blocked();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
